// File: rtl/vga_timing_param.sv
// Parameterised VGA/DVI raster timing generator with registered decodes.
// Ports: pclk, rst (async, active-high), en; hcount/vcount [CW-1:0];
//   hsync, vsync, hblnk, vblnk, de, sof, eol;
//   frame_cnt [15:0] only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_param #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          sof,
  output logic          eol
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so boundaries equal to 2^CW still fit.
  localparam logic [CW:0] H_LAST = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_LAST = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] H_A    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] V_A    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_S   = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_E   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_S   = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_E   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HS_ON  = (HS_POL != 0);
  localparam logic        VS_ON  = (VS_POL != 0);

  if (H_TOTAL > (1 << CW)) begin : g_h_chk
    $error("vga_timing_param: H_TOTAL exceeds 2^CW");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_chk
    $error("vga_timing_param: V_TOTAL exceeds 2^CW");
  end

  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          hblnk_q, hblnk_d;
  logic          vblnk_q, vblnk_d;
  logic          de_q, de_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic [CW:0]   h_cur, v_cur, h_nxt, v_nxt;
  logic          h_wrap, v_wrap;

  assign h_cur  = {1'b0, hcount_q};
  assign v_cur  = {1'b0, vcount_q};
  assign h_wrap = (h_cur == H_LAST);
  assign v_wrap = (v_cur == V_LAST);
  assign h_nxt  = {1'b0, hcount_d};
  assign v_nxt  = {1'b0, vcount_d};

  // Decodes are taken from the next counter values so that every
  // registered output lines up with the registered counters.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    if (en) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      sof_d = h_wrap && v_wrap;
      eol_d = (h_nxt == H_LAST);
    end
    hblnk_d = (h_nxt >= H_A);
    vblnk_d = (v_nxt >= V_A);
    de_d    = !hblnk_d && !vblnk_d;
    hsync_d = (h_nxt >= HS_S && h_nxt < HS_E) ? HS_ON : ~HS_ON;
    vsync_d = (v_nxt >= VS_S && v_nxt < VS_E) ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblnk  = hblnk_q;
  assign vblnk  = vblnk_q;
  assign de     = de_q;
  assign sof    = sof_q;
  assign eol    = eol_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts alongside sof so the new value appears with the pulse.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, sof_d};
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: default-config and small
// negative-polarity instances driven from one clock/reset/enable.
module tb_vga_timing_param;

  logic clk, rst, en;

  logic [11:0] d_h, d_v;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_sof, d_eol;
  logic [4:0] s_h, s_v;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_sof, s_eol;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  vga_timing_param dut_d (
    .pclk(clk), .rst(rst), .en(en),
    .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb),
    .de(d_de), .sof(d_sof), .eol(d_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_param #(
    .CW(5),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) dut_s (
    .pclk(clk), .rst(rst), .en(en),
    .hcount(s_h), .vcount(s_v),
    .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb),
    .de(s_de), .sof(s_sof), .eol(s_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int k = 0;

  typedef struct {
    int k;
    int h;
    int v;
    logic [6:0] f;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en) k++;
  endtask

  function automatic logic [6:0] sflags();
    return {s_hb, s_vb, s_de, s_hs, s_vs, s_eol, s_sof};
  endfunction

  initial begin
    int bad_h, bad_hs, hs_cnt, n_eol, last_eol, per;
    int c_de, c_sof, c_eol, fz_eol, fz_mv, ev;

    // f = {hblnk, vblnk, de, hsync, vsync, eol, sof}; small dut
    tbl[0]  = '{0,  0,  0, 7'b0011100};
    tbl[1]  = '{7,  7,  0, 7'b0011100};
    tbl[2]  = '{8,  8,  0, 7'b1001100};
    tbl[3]  = '{10, 10, 0, 7'b1000100};
    tbl[4]  = '{11, 11, 0, 7'b1000100};
    tbl[5]  = '{12, 12, 0, 7'b1001100};
    tbl[6]  = '{13, 13, 0, 7'b1001110};
    tbl[7]  = '{14, 0,  1, 7'b0011100};
    tbl[8]  = '{56, 0,  4, 7'b0101100};
    tbl[9]  = '{70, 0,  5, 7'b0101000};
    tbl[10] = '{83, 13, 5, 7'b1101010};
    tbl[11] = '{84, 0,  6, 7'b0101100};
    tbl[12] = '{97, 13, 6, 7'b1101110};
    tbl[13] = '{98, 0,  0, 7'b0011101};
    tbl[14] = '{99, 1,  0, 7'b0011100};

    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst d_h", int'(d_h), 0);
    chk("rst d_v", int'(d_v), 0);
    chk("rst d_flags",
        int'({d_hb, d_vb, d_de, d_hs, d_vs, d_eol, d_sof}),
        int'(7'b0010000));
    chk("rst s_flags", int'(sflags()), int'(7'b0011100));

    rst = 1'b0;
    en  = 1'b1;
    k   = 0;
    for (int i = 0; i < 15; i++) begin
      while (k < tbl[i].k) step();
      chk($sformatf("vec k=%0d h", tbl[i].k), int'(s_h), tbl[i].h);
      chk($sformatf("vec k=%0d v", tbl[i].k), int'(s_v), tbl[i].v);
      chk($sformatf("vec k=%0d flags", tbl[i].k),
          int'(sflags()), int'(tbl[i].f));
    end

    // One full small frame: 8x4 active, one sof, seven eols.
    c_de = 0; c_sof = 0; c_eol = 0;
    for (int i = 0; i < 98; i++) begin
      step();
      c_de  += int'(s_de);
      c_sof += int'(s_sof);
      c_eol += int'(s_eol);
    end
    chk("small de/frame", c_de, 32);
    chk("small sof/frame", c_sof, 1);
    chk("small eol/frame", c_eol, 7);

    // Default instance: two lines of hsync window and eol spacing.
    bad_h = 0; bad_hs = 0; hs_cnt = 0;
    n_eol = 0; last_eol = -1; per = 0;
    for (int i = 0; i < 2 * 1688; i++) begin
      int h;
      step();
      h = k % 1688;
      if (int'(d_h) != h || int'(d_v) != k / 1688) bad_h++;
      if (d_hs != (h >= 1328 && h <= 1439)) bad_hs++;
      if (d_vs !== 1'b0) bad_hs++;
      hs_cnt += int'(d_hs);
      if (d_eol) begin
        if (h != 1687) bad_h++;
        if (last_eol >= 0) per = k - last_eol;
        last_eol = k;
        n_eol++;
      end
    end
    chk("def counters", bad_h, 0);
    chk("def hsync window", bad_hs, 0);
    chk("def hsync count", hs_cnt, 224);
    chk("def eol count", n_eol, 2);
    chk("def eol period", per, 1688);

    // Freeze on the eol cycle of the small instance.
    while (k % 14 != 13) step();
    chk("frz eol", int'(s_eol), 1);
    chk("frz h", int'(s_h), 13);
    ev = (k / 14) % 7;
    en = 1'b0;
    fz_eol = 0; fz_mv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      fz_eol += int'(s_eol);
      if (int'(s_h) != 13 || int'(s_v) != ev) fz_mv++;
      if (int'(d_h) != k % 1688) fz_mv++;
    end
    chk("frz eol held", fz_eol, 0);
    chk("frz counters", fz_mv, 0);
    en = 1'b1;
    step();
    chk("frz wrap h", int'(s_h), 0);
    chk("frz wrap v", int'(s_v), (ev + 1) % 7);
    chk("frz wrap eol", int'(s_eol), 0);

    // Asynchronous reset in the middle of a cycle.
    repeat (20) step();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst s_h", int'(s_h), 0);
    chk("arst s_v", int'(s_v), 0);
    chk("arst s_flags", int'(sflags()), int'(7'b0011100));
    chk("arst d_h", int'(d_h), 0);
    chk("arst d_flags",
        int'({d_hb, d_vb, d_de, d_hs, d_vs, d_eol, d_sof}),
        int'(7'b0010000));
    #2 rst = 1'b0;
    k = 0;
    c_sof = 0;
    step();
    chk("arst first h", int'(s_h), 1);
    c_sof += int'(s_sof);
    for (int i = 0; i < 20; i++) begin
      step();
      c_sof += int'(s_sof);
    end
    chk("arst no sof", c_sof, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    while (k < 3 * 98) step();
    chk("fc 3 frames", int'(s_fc), 3);
    step();
    force dut_s.frame_cnt_q = 16'hFFFF;
    #1 release dut_s.frame_cnt_q;
    while (k < 4 * 98) step();
    chk("fc wrap", int'(s_fc), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
